// File: rtl/ddr3_dfi_responder.sv
// ----------------------------------------------------------------------------
// ddr3_dfi_responder
//   Behavioural DDR3 memory model seen from the DFI side of a controller.
//   Decodes DFI commands, tracks per-bank open rows, accepts 4-beat write
//   bursts through a small address FIFO and returns 4-beat read bursts a fixed
//   RD_LAT clocks after the RD command.
//
// Ports
//   clock, reset_n          sole clock (rising) / async active-low reset
//   dfi_cke_i               clock enable, commands ignored while low
//   dfi_cs_ni..dfi_we_ni    command strobes
//   dfi_bank_i, dfi_addr_i  bank / row-or-column address
//   dfi_wren_i, dfi_mask_i,
//   dfi_data_i              write beat valid, byte mask (1 = keep), data
//   dfi_rvld_o, dfi_last_o,
//   dfi_data_o              read beat valid, final beat, data
//   err_o                   sticky protocol error
//
// Configuration
//   DFI_RESPONDER_CHECK_EN  when defined, builds the protocol checker that
//                           drives err_o; otherwise err_o is tied to 0.
// ----------------------------------------------------------------------------
module ddr3_dfi_responder #(
    parameter int DFI_DQ_WIDTH = 32,
    parameter int DFI_DM_WIDTH = 4,
    parameter int DDR_ROW_BITS = 15,
    parameter int DDR_COL_BITS = 10,
    parameter int MEM_BITS     = 10,
    parameter int RD_LAT       = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    dfi_cke_i,
    input  logic                    dfi_cs_ni,
    input  logic                    dfi_ras_ni,
    input  logic                    dfi_cas_ni,
    input  logic                    dfi_we_ni,
    input  logic [2:0]              dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
    input  logic                    dfi_wren_i,
    input  logic [DFI_DM_WIDTH-1:0] dfi_mask_i,
    input  logic [DFI_DQ_WIDTH-1:0] dfi_data_i,
    output logic                    dfi_rvld_o,
    output logic                    dfi_last_o,
    output logic [DFI_DQ_WIDTH-1:0] dfi_data_o,
    output logic                    err_o
);
    localparam int BYTE_W = DFI_DQ_WIDTH / DFI_DM_WIDTH;
    // The read delay line holds RD_LAT-1 stages; the output register is the last.
    localparam int DL     = RD_LAT - 1;

    // Burst base index with the two beat bits dropped (they are always 00).
    typedef logic [MEM_BITS-3:0] cbase_t;

    // ---------------- command decode ----------------
    logic [3:0] cmd;
    logic       is_act, is_rd, is_wr, is_pre;

    assign cmd    = {dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni};
    assign is_act = dfi_cke_i && (cmd == 4'b0011);
    assign is_rd  = dfi_cke_i && (cmd == 4'b0101);
    assign is_wr  = dfi_cke_i && (cmd == 4'b0100);
    assign is_pre = dfi_cke_i && (cmd == 4'b0010);
    // REF (0001) and MRS (0000) are accepted and deliberately do nothing.

    // ---------------- bank records ----------------
    logic [7:0]                   open_q;
    logic [7:0][DDR_ROW_BITS-1:0] row_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            open_q <= '0;
            row_q  <= '0;
        end else if (is_act) begin
            open_q[dfi_bank_i] <= 1'b1;
            row_q[dfi_bank_i]  <= dfi_addr_i;
        end else if (is_pre) begin
            if (dfi_addr_i[10]) open_q <= '0;
            else                open_q[dfi_bank_i] <= 1'b0;
        end
    end

    // Full index is {bank,row,col[CSB:3],beat}; keep only what fits in memory.
    cbase_t cmd_base;
    assign cmd_base = cbase_t'({dfi_bank_i, row_q[dfi_bank_i],
                                dfi_addr_i[DDR_COL_BITS-1:3]});

    // ---------------- write address FIFO ----------------
    logic [3:0][MEM_BITS-3:0] wfifo_q;
    logic [2:0]               wr_ptr_q, rd_ptr_q;
    logic [1:0]               wbeat_q;
    logic                     wf_empty, wf_full, wr_beat, wf_pop, wf_push;
    logic [MEM_BITS-1:0]      waddr;

    assign wf_empty = (wr_ptr_q == rd_ptr_q);
    assign wf_full  = (wr_ptr_q[1:0] == rd_ptr_q[1:0]) && (wr_ptr_q[2] != rd_ptr_q[2]);
    assign wr_beat  = dfi_wren_i && !wf_empty;          // orphan beats write nothing
    assign wf_pop   = wr_beat && (wbeat_q == 2'd3);
    // Pop is taken before push, so a full FIFO still accepts a WR on its last beat.
    assign wf_push  = is_wr && (!wf_full || wf_pop);
    assign waddr    = {wfifo_q[rd_ptr_q[1:0]], wbeat_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wfifo_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wbeat_q  <= '0;
        end else begin
            if (wr_beat) wbeat_q  <= wbeat_q + 2'd1;
            if (wf_pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
            if (wf_push) begin
                wfifo_q[wr_ptr_q[1:0]] <= cmd_base;
                wr_ptr_q               <= wr_ptr_q + 3'd1;
            end
        end
    end

    // ---------------- storage (no reset: contents survive reset) ----------------
    logic [DFI_DQ_WIDTH-1:0] mem_q [0:(1<<MEM_BITS)-1];

    always_ff @(posedge clock) begin
        if (wr_beat) begin
            for (int i = 0; i < DFI_DM_WIDTH; i++) begin
                if (!dfi_mask_i[i]) mem_q[waddr][i*BYTE_W +: BYTE_W] <= dfi_data_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // ---------------- read delay line ----------------
    logic [DL-1:0]              rd_vld_q;
    logic [DL-1:0][MEM_BITS-3:0] rd_base_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q  <= '0;
            rd_base_q <= '0;
        end else begin
            rd_vld_q[0]  <= is_rd;
            rd_base_q[0] <= cmd_base;
            for (int i = 1; i < DL; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_base_q[i] <= rd_base_q[i-1];
            end
        end
    end

    // ---------------- read burst sequencer ----------------
    logic                    rvld_q, rvld_d, last_q, last_d;
    logic [1:0]              rbeat_q, rbeat_d;
    cbase_t                  rbase_q, rbase_d;
    logic [DFI_DQ_WIDTH-1:0] rdata_q;
    logic                    rd_busy, rd_start;
    logic [MEM_BITS-1:0]     raddr;

    // A burst on its final beat is not busy, so a start lands back-to-back.
    assign rd_busy  = rvld_q && (rbeat_q != 2'd3);
    assign rd_start = rd_vld_q[DL-1] && !rd_busy;

    always_comb begin
        rvld_d  = 1'b0;
        rbeat_d = rbeat_q;
        rbase_d = rbase_q;
        if (rd_start) begin
            rvld_d  = 1'b1;
            rbeat_d = 2'd0;
            rbase_d = rd_base_q[DL-1];
        end else if (rd_busy) begin
            rvld_d  = 1'b1;
            rbeat_d = rbeat_q + 2'd1;
        end
    end

    assign last_d = rvld_d && (rbeat_d == 2'd3);
    assign raddr  = {rbase_d, rbeat_d};

    // Memory write uses <= too, so a same-cycle read of that word sees old data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvld_q  <= 1'b0;
            last_q  <= 1'b0;
            rbeat_q <= '0;
            rbase_q <= '0;
            rdata_q <= '0;
        end else begin
            rvld_q  <= rvld_d;
            last_q  <= last_d;
            rbeat_q <= rbeat_d;
            rbase_q <= rbase_d;
            if (rvld_d) rdata_q <= mem_q[raddr];
        end
    end

    assign dfi_rvld_o = rvld_q;
    assign dfi_last_o = last_q;
    assign dfi_data_o = rdata_q;

    // ---------------- protocol checker ----------------
`ifdef DFI_RESPONDER_CHECK_EN
    logic err_q, err_ev, rd_drop;

    assign rd_drop = rd_vld_q[DL-1] && rd_busy;
    assign err_ev  = ((is_rd || is_wr) && !open_q[dfi_bank_i])
                   || (is_act && open_q[dfi_bank_i])
                   || rd_drop
                   || (is_wr && !wf_push)
                   || (dfi_wren_i && wf_empty);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else if (err_ev) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
